// File: rtl/mmu_defs_pkg.sv
// mmu_defs: shared widths, pool geometry, fail codes, FIFO depths and record layouts for the page MMU.
package mmu_defs;
   localparam int REQ_ID_WIDTH        = 8;
   localparam int REQ_SIZE_TYPE_WIDTH = 4;
   localparam int ALL_PAGE_IDX_WIDTH  = 15;
   localparam int FAIL_REASON_WIDTH   = 2;
   localparam int PAGE_COUNT          = 4096;
   localparam int PAGE_NUM_WIDTH      = 12;
   localparam int MAX_ALLOC_PAGES     = 8;
   localparam int REQ_FIFO_DEPTH      = 16;
   localparam int RSP_FIFO_DEPTH      = 16;
   localparam int RECYCLE_FIFO_DEPTH  = PAGE_COUNT;

   typedef enum logic [FAIL_REASON_WIDTH-1:0] {
      FAIL_NONE     = 2'd0,
      FAIL_NO_SPACE = 2'd1,
      FAIL_BAD_SIZE = 2'd2,
      FAIL_BAD_FREE = 2'd3
   } fail_e;

   typedef struct packed {
      logic [REQ_ID_WIDTH-1:0]        id;
      logic [REQ_SIZE_TYPE_WIDTH-1:0] cnt;
   } alloc_req_t;

   typedef struct packed {
      logic [REQ_ID_WIDTH-1:0]        id;
      logic [ALL_PAGE_IDX_WIDTH-1:0]  page_idx;
      logic [REQ_SIZE_TYPE_WIDTH-1:0] cnt;
   } free_req_t;

   typedef struct packed {
      logic [REQ_ID_WIDTH-1:0]       id;
      logic [ALL_PAGE_IDX_WIDTH-1:0] page_idx;
      logic                          fail;
      fail_e                         reason;
   } alloc_rsp_t;

   typedef struct packed {
      logic [REQ_ID_WIDTH-1:0] id;
      logic                    fail;
      fail_e                   reason;
   } free_rsp_t;

   function automatic logic size_ok(input logic [REQ_SIZE_TYPE_WIDTH-1:0] n);
      return n != '0 && n <= REQ_SIZE_TYPE_WIDTH'(MAX_ALLOC_PAGES);
   endfunction
endpackage

// File: rtl/mmu_sync_fifo.sv
// mmu_sync_fifo: first-word-fall-through FIFO; overflow pushes and underflow pops are ignored.
// DEPTH must be a power of two so the pointers wrap naturally; dout reads 0 while empty.
module mmu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push = push && cnt_q != CW'(DEPTH);
      do_pop  = pop && cnt_q != '0;
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

   assign dout  = cnt_q == '0 ? '0 : mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/mmu_top.sv
// mmu_top: 4K-page allocator with queued alloc/free requests and FWFT response queues.
// Each engine result sits one cycle in a stage register before entering its response FIFO.
module mmu_top
   import mmu_defs::*;
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           alloc_req_submit,
   input  logic [REQ_ID_WIDTH-1:0]        alloc_req_id,
   input  logic [REQ_SIZE_TYPE_WIDTH-1:0] alloc_req_page_count,
   input  logic                           free_req_submit,
   input  logic [REQ_ID_WIDTH-1:0]        free_req_id,
   input  logic [ALL_PAGE_IDX_WIDTH-1:0]  free_req_page_idx,
   input  logic [REQ_SIZE_TYPE_WIDTH-1:0] free_req_page_count,
   input  logic                           alloc_rsp_pop,
   input  logic                           free_rsp_pop,
   output logic [REQ_ID_WIDTH-1:0]        alloc_rsp_id,
   output logic [ALL_PAGE_IDX_WIDTH-1:0]  alloc_rsp_page_idx,
   output logic                           alloc_rsp_fail,
   output logic [FAIL_REASON_WIDTH-1:0]   alloc_rsp_fail_reason,
   output logic [REQ_ID_WIDTH-1:0]        free_rsp_id,
   output logic                           free_rsp_fail,
   output logic [FAIL_REASON_WIDTH-1:0]   free_rsp_fail_reason,
   output logic                           alloc_req_fifo_full,
   output logic                           free_req_fifo_full,
   output logic                           alloc_rsp_fifo_not_empty,
   output logic                           free_rsp_fifo_not_empty
);
   localparam int RQ_CW = $clog2(REQ_FIFO_DEPTH+1);
   localparam int RS_CW = $clog2(RSP_FIFO_DEPTH+1);
   localparam int RC_CW = $clog2(RECYCLE_FIFO_DEPTH+1);

   alloc_req_t                a_req_in, a_head;
   free_req_t                 f_req_in, f_head;
   alloc_rsp_t                a_rsp_d, a_stg_q, a_rsp_head;
   free_rsp_t                 f_rsp_d, f_stg_q, f_rsp_head;
   logic                      a_stg_v_q, a_stg_v_d, f_stg_v_q, f_stg_v_d;
   logic [RC_CW-1:0]          fresh_q, fresh_d, rec_cnt;
   logic [RQ_CW-1:0]          a_req_cnt, f_req_cnt;
   logic [RS_CW-1:0]          a_rsp_cnt, f_rsp_cnt;
   logic [PAGE_NUM_WIDTH-1:0] rec_head, rec_din, page;
   logic                      rec_push, rec_pop, rec_empty, rec_full;
   logic                      a_go, f_go, a_bad, a_have, a_ok, f_bad, f_ok;

   assign a_req_in = '{id: alloc_req_id, cnt: alloc_req_page_count};
   assign f_req_in = '{id: free_req_id, page_idx: free_req_page_idx, cnt: free_req_page_count};

   always_comb begin
      rec_empty = rec_cnt == '0;
      rec_full  = rec_cnt == RC_CW'(RECYCLE_FIFO_DEPTH);
      // a staged result already owns one response slot
      a_go      = a_req_cnt != '0 && a_rsp_cnt < (a_stg_v_q ? RS_CW'(RSP_FIFO_DEPTH-1) : RS_CW'(RSP_FIFO_DEPTH));
      f_go      = f_req_cnt != '0 && f_rsp_cnt < (f_stg_v_q ? RS_CW'(RSP_FIFO_DEPTH-1) : RS_CW'(RSP_FIFO_DEPTH));
      a_bad     = !size_ok(a_head.cnt);
      a_have    = !rec_empty || fresh_q < RC_CW'(PAGE_COUNT);
      a_ok      = !a_bad && a_have;
      page      = rec_empty ? fresh_q[PAGE_NUM_WIDTH-1:0] : rec_head;
      a_rsp_d   = '{id: a_head.id,
                    page_idx: a_ok ? {page, 3'b000} : '0,
                    fail: !a_ok,
                    reason: a_bad ? FAIL_BAD_SIZE : a_have ? FAIL_NONE : FAIL_NO_SPACE};
      rec_pop   = a_go && a_ok && !rec_empty;
      fresh_d   = a_go && a_ok && rec_empty ? fresh_q + 1'b1 : fresh_q;
      f_bad     = f_head.page_idx[2:0] != 3'b000 || !size_ok(f_head.cnt);
      f_ok      = !f_bad && !rec_full;
      f_rsp_d   = '{id: f_head.id,
                    fail: !f_ok,
                    reason: f_bad ? FAIL_BAD_FREE : rec_full ? FAIL_NO_SPACE : FAIL_NONE};
      rec_push  = f_go && f_ok;
      rec_din   = f_head.page_idx[ALL_PAGE_IDX_WIDTH-1:3];
      a_stg_v_d = a_go;
      f_stg_v_d = f_go;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fresh_q   <= '0;
         a_stg_v_q <= 1'b0;
         f_stg_v_q <= 1'b0;
         a_stg_q   <= '0;
         f_stg_q   <= '0;
      end else begin
         fresh_q   <= fresh_d;
         a_stg_v_q <= a_stg_v_d;
         f_stg_v_q <= f_stg_v_d;
         a_stg_q   <= a_rsp_d;
         f_stg_q   <= f_rsp_d;
      end
   end

   mmu_sync_fifo #(.WIDTH($bits(alloc_req_t)), .DEPTH(REQ_FIFO_DEPTH)) u_alloc_req (
      .clk(clk), .rst_n(rst_n), .push(alloc_req_submit), .din(a_req_in),
      .pop(a_go), .dout(a_head), .count(a_req_cnt));

   mmu_sync_fifo #(.WIDTH($bits(free_req_t)), .DEPTH(REQ_FIFO_DEPTH)) u_free_req (
      .clk(clk), .rst_n(rst_n), .push(free_req_submit), .din(f_req_in),
      .pop(f_go), .dout(f_head), .count(f_req_cnt));

   mmu_sync_fifo #(.WIDTH($bits(alloc_rsp_t)), .DEPTH(RSP_FIFO_DEPTH)) u_alloc_rsp (
      .clk(clk), .rst_n(rst_n), .push(a_stg_v_q), .din(a_stg_q),
      .pop(alloc_rsp_pop), .dout(a_rsp_head), .count(a_rsp_cnt));

   mmu_sync_fifo #(.WIDTH($bits(free_rsp_t)), .DEPTH(RSP_FIFO_DEPTH)) u_free_rsp (
      .clk(clk), .rst_n(rst_n), .push(f_stg_v_q), .din(f_stg_q),
      .pop(free_rsp_pop), .dout(f_rsp_head), .count(f_rsp_cnt));

   mmu_sync_fifo #(.WIDTH(PAGE_NUM_WIDTH), .DEPTH(RECYCLE_FIFO_DEPTH)) u_recycle (
      .clk(clk), .rst_n(rst_n), .push(rec_push), .din(rec_din),
      .pop(rec_pop), .dout(rec_head), .count(rec_cnt));

   assign alloc_rsp_id             = a_rsp_head.id;
   assign alloc_rsp_page_idx       = a_rsp_head.page_idx;
   assign alloc_rsp_fail           = a_rsp_head.fail;
   assign alloc_rsp_fail_reason    = a_rsp_head.reason;
   assign free_rsp_id              = f_rsp_head.id;
   assign free_rsp_fail            = f_rsp_head.fail;
   assign free_rsp_fail_reason     = f_rsp_head.reason;
   assign alloc_req_fifo_full      = a_req_cnt == RQ_CW'(REQ_FIFO_DEPTH);
   assign free_req_fifo_full       = f_req_cnt == RQ_CW'(REQ_FIFO_DEPTH);
   assign alloc_rsp_fifo_not_empty = a_rsp_cnt != '0;
   assign free_rsp_fifo_not_empty  = f_rsp_cnt != '0;
endmodule

// File: tb/tb_mmu_top.sv
// tb_mmu_top: directed and randomized checks of mmu_top against a queue-based pool model.
module tb_mmu_top;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alloc_req_submit = 1'b0, free_req_submit = 1'b0;
   logic [7:0]  alloc_req_id = '0, free_req_id = '0;
   logic [3:0]  alloc_req_page_count = '0, free_req_page_count = '0;
   logic [14:0] free_req_page_idx = '0;
   logic        alloc_rsp_pop = 1'b0, free_rsp_pop = 1'b0;
   logic [7:0]  alloc_rsp_id, free_rsp_id;
   logic [14:0] alloc_rsp_page_idx;
   logic        alloc_rsp_fail, free_rsp_fail;
   logic [1:0]  alloc_rsp_fail_reason, free_rsp_fail_reason;
   logic        alloc_req_fifo_full, free_req_fifo_full;
   logic        alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty;

   mmu_top dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_req_submit(alloc_req_submit), .alloc_req_id(alloc_req_id),
      .alloc_req_page_count(alloc_req_page_count),
      .free_req_submit(free_req_submit), .free_req_id(free_req_id),
      .free_req_page_idx(free_req_page_idx), .free_req_page_count(free_req_page_count),
      .alloc_rsp_pop(alloc_rsp_pop), .free_rsp_pop(free_rsp_pop),
      .alloc_rsp_id(alloc_rsp_id), .alloc_rsp_page_idx(alloc_rsp_page_idx),
      .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
      .free_rsp_id(free_rsp_id), .free_rsp_fail(free_rsp_fail),
      .free_rsp_fail_reason(free_rsp_fail_reason),
      .alloc_req_fifo_full(alloc_req_fifo_full), .free_req_fifo_full(free_req_fifo_full),
      .alloc_rsp_fifo_not_empty(alloc_rsp_fifo_not_empty),
      .free_rsp_fifo_not_empty(free_rsp_fifo_not_empty));

   always #5 clk = ~clk;

   typedef struct { int id; int idx; int fail; int reason; } exp_t;

   exp_t qa[$], qf[$];
   int   rec[$], held[$];
   int   fresh;
   int   n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic void m_reset();
      qa.delete(); qf.delete(); rec.delete(); held.delete();
      fresh = 0;
   endfunction

   // pool model: recycled pages first, then the fresh counter
   function automatic void m_alloc(input int id, input int cnt);
      exp_t e;
      int   p;
      e = '{id: id, idx: 0, fail: 1, reason: 0};
      if (cnt < 1 || cnt > 8) e.reason = 2;
      else if (rec.size() == 0 && fresh == 4096) e.reason = 1;
      else begin
         if (rec.size() > 0) p = rec.pop_front();
         else begin p = fresh; fresh++; end
         held.push_back(p);
         e.idx = p * 8; e.fail = 0;
      end
      qa.push_back(e);
   endfunction

   function automatic void m_free(input int id, input int idx, input int cnt);
      exp_t e;
      e = '{id: id, idx: 0, fail: 1, reason: 0};
      if (idx % 8 != 0 || cnt < 1 || cnt > 8) e.reason = 3;
      else if (rec.size() == 4096) e.reason = 1;
      else begin rec.push_back(idx / 8); e.fail = 0; end
      qf.push_back(e);
   endfunction

   task automatic alloc(input int id, input int cnt, input bit keep = 1'b1);
      alloc_req_submit = 1'b1; alloc_req_id = 8'(id); alloc_req_page_count = 4'(cnt);
      if (keep) m_alloc(id, cnt);
      @(negedge clk);
      alloc_req_submit = 1'b0;
   endtask

   task automatic free(input int id, input int idx, input int cnt, input bit keep = 1'b1);
      free_req_submit = 1'b1; free_req_id = 8'(id); free_req_page_idx = 15'(idx);
      free_req_page_count = 4'(cnt);
      if (keep) m_free(id, idx, cnt);
      @(negedge clk);
      free_req_submit = 1'b0;
   endtask

   task automatic both(input int aid, input int acnt, input int fid, input int fidx, input int fcnt);
      alloc_req_submit = 1'b1; alloc_req_id = 8'(aid); alloc_req_page_count = 4'(acnt);
      free_req_submit = 1'b1; free_req_id = 8'(fid); free_req_page_idx = 15'(fidx);
      free_req_page_count = 4'(fcnt);
      m_alloc(aid, acnt);
      m_free(fid, fidx, fcnt);
      @(negedge clk);
      alloc_req_submit = 1'b0; free_req_submit = 1'b0;
   endtask

   task automatic drain();
      exp_t e;
      int   w;
      while (qa.size() > 0) begin
         w = 0;
         while (!alloc_rsp_fifo_not_empty && w < 60) begin @(negedge clk); w++; end
         if (!alloc_rsp_fifo_not_empty) begin
            check("alloc_rsp_timeout", 0, 1);
            qa.delete();
         end else begin
            e = qa.pop_front();
            check("alloc_id", int'(alloc_rsp_id), e.id & 255);
            check("alloc_idx", int'(alloc_rsp_page_idx), e.idx);
            check("alloc_fail", int'(alloc_rsp_fail), e.fail);
            check("alloc_reason", int'(alloc_rsp_fail_reason), e.reason);
            alloc_rsp_pop = 1'b1;
            @(negedge clk);
            alloc_rsp_pop = 1'b0;
         end
      end
      while (qf.size() > 0) begin
         w = 0;
         while (!free_rsp_fifo_not_empty && w < 60) begin @(negedge clk); w++; end
         if (!free_rsp_fifo_not_empty) begin
            check("free_rsp_timeout", 0, 1);
            qf.delete();
         end else begin
            e = qf.pop_front();
            check("free_id", int'(free_rsp_id), e.id & 255);
            check("free_fail", int'(free_rsp_fail), e.fail);
            check("free_reason", int'(free_rsp_fail_reason), e.reason);
            free_rsp_pop = 1'b1;
            @(negedge clk);
            free_rsp_pop = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_reset();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, p, n;
      m_reset();
      repeat (3) @(negedge clk);
      check("rst_a_full", int'(alloc_req_fifo_full), 0);
      check("rst_f_full", int'(free_req_fifo_full), 0);
      check("rst_a_ne", int'(alloc_rsp_fifo_not_empty), 0);
      check("rst_f_ne", int'(free_rsp_fifo_not_empty), 0);
      check("rst_a_idx", int'(alloc_rsp_page_idx), 0);
      check("rst_f_reason", int'(free_rsp_fail_reason), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_a_ne", int'(alloc_rsp_fifo_not_empty), 0);
      check("post_rst_a_full", int'(alloc_req_fifo_full), 0);

      // latency: accepted at edge N, visible only after edge N+2
      alloc_req_submit = 1'b1; alloc_req_id = 8'd0; alloc_req_page_count = 4'd1;
      m_alloc(0, 1);
      @(posedge clk);
      #1 alloc_req_submit = 1'b0;
      @(negedge clk); check("lat_after_n", int'(alloc_rsp_fifo_not_empty), 0);
      @(negedge clk); check("lat_after_n1", int'(alloc_rsp_fifo_not_empty), 0);
      @(negedge clk); check("lat_after_n2", int'(alloc_rsp_fifo_not_empty), 1);
      drain();
      do_reset();

      for (int i = 0; i < 10; i++) alloc(i, 1);
      drain();
      for (int i = 0; i < 10; i++) free(i, i * 8, 1);
      drain();
      alloc(10, 1);
      drain();

      alloc(20, 0);
      alloc(21, 9);
      free(22, 5, 1);
      free(23, 16, 0);
      free(24, 24, 9);
      drain();

      // same cycle: alloc must not see the page freed alongside it
      both(30, 2, 31, 8 * 100, 1);
      drain();

      for (int it = 0; it < 150; it++) begin
         n = $urandom_range(1, 4);
         for (int j = 0; j < n; j++) begin
            k = $urandom_range(0, 3);
            if (k < 2) alloc($urandom_range(0, 255), $urandom_range(0, 10));
            else if (k == 2 && held.size() > 0) begin
               p = $urandom_range(0, held.size() - 1);
               k = held[p];
               held.delete(p);
               free($urandom_range(0, 255), k * 8, $urandom_range(1, 8));
            end else free($urandom_range(0, 255), $urandom_range(0, 32767), $urandom_range(0, 15));
         end
         drain();
      end

      do_reset();
      for (int b = 0; b < 512; b++) begin
         for (int j = 0; j < 8; j++) alloc(b * 8 + j, 1);
         if (b == 511) check("last_alloc_model_idx", qa[7].idx, 32760);
         drain();
      end
      alloc(77, 1);
      drain();

      // no pops: 16 requests queue behind 16 buffered responses, the rest are dropped
      do_reset();
      for (int i = 0; i < 40; i++) alloc(i, 1, i < 32);
      check("a_req_full", int'(alloc_req_fifo_full), 1);
      drain();
      repeat (5) @(negedge clk);
      check("a_no_extra", int'(alloc_rsp_fifo_not_empty), 0);

      for (int i = 0; i < 40; i++) alloc(i, 1, 1'b0);
      for (int i = 0; i < 3; i++) free(i, 3, 1, 1'b0);
      repeat (3) @(negedge clk);
      check("pre_rst_a_full", int'(alloc_req_fifo_full), 1);
      check("pre_rst_f_ne", int'(free_rsp_fifo_not_empty), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_a_full", int'(alloc_req_fifo_full), 0);
      check("mid_rst_a_ne", int'(alloc_rsp_fifo_not_empty), 0);
      check("mid_rst_f_ne", int'(free_rsp_fifo_not_empty), 0);
      check("mid_rst_a_idx", int'(alloc_rsp_page_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_reset();
      @(negedge clk);
      alloc(5, 3);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
